// File: rtl/fifo_link_tx.sv
// fifo_link_tx: credit-based link transmitter draining a local FIFO onto an inter-PE link.
//
// Ports:
//   clk, rstN          clock and asynchronous active-low reset
//   enable             level, 1 = transmit tokens
//   drainReq           pulse, request orderly stop (send out, wait for all credits back)
//   fifoData/fifoEmpty head token and empty flag of the local FIFO
//   fifoRead           combinational pop strobe to the local FIFO
//   linkValid/linkData registered token on the link
//   creditReturn       pulse, remote consumer freed one slot
//   credits            free slots in the remote FIFO
//   busy               running or draining
//   drained            one-cycle pulse when a drain completes
//   creditErr          sticky, credit returned while already at full credit
module fifo_link_tx #(
    parameter int DATA_SIZE = 8,
    parameter int CREDITS   = 4,
    parameter int CREDIT_W  = 3
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 enable,
    input  logic                 drainReq,
    input  logic [DATA_SIZE-1:0] fifoData,
    input  logic                 fifoEmpty,
    output logic                 fifoRead,
    output logic                 linkValid,
    output logic [DATA_SIZE-1:0] linkData,
    input  logic                 creditReturn,
    output logic [CREDIT_W-1:0]  credits,
    output logic                 busy,
    output logic                 drained,
    output logic                 creditErr
);
    localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(CREDITS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credits_q, credits_d;
    logic                  valid_q;
    logic [DATA_SIZE-1:0]  data_q;
    logic                  drained_q, err_q;
    logic                  send, bad_ret, drain_done;

    always_comb begin
        send       = state_q != IDLE && !fifoEmpty && credits_q != '0;
        // a return at full credit with no send in flight has no token to pay for
        bad_ret    = creditReturn && !send && credits_q == FULL;
        drain_done = state_q == DRAIN && fifoEmpty && credits_q == FULL && !send;
        credits_d  = (send && !creditReturn) ? credits_q - CREDIT_W'(1) :
                     (!send && creditReturn && !bad_ret) ? credits_q + CREDIT_W'(1) : credits_q;
        state_d    = state_q;
        unique case (state_q)
            IDLE:    state_d = enable ? RUN : IDLE;
            RUN:     state_d = drainReq ? DRAIN : (enable ? RUN : IDLE);
            DRAIN:   state_d = drain_done ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            credits_q <= FULL;
            valid_q   <= 1'b0;
            data_q    <= '0;
            drained_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            valid_q   <= send;
            data_q    <= send ? fifoData : data_q;
            drained_q <= drain_done;
            err_q     <= err_q | bad_ret;
        end
    end

    assign fifoRead  = send;
    assign linkValid = valid_q;
    assign linkData  = data_q;
    assign credits   = credits_q;
    assign busy      = state_q != IDLE;
    assign drained   = drained_q;
    assign creditErr = err_q;
endmodule

// File: tb/tb_fifo_link_tx.sv
module tb_fifo_link_tx;
    localparam int CR = 4;

    logic       clk = 1'b0, rstN = 1'b0;
    logic       enable = 1'b0, drainReq = 1'b0, fifoEmpty = 1'b1, creditReturn = 1'b0;
    logic [7:0] fifoData = '0;
    logic       fifoRead, linkValid, busy, drained, creditErr;
    logic [7:0] linkData;
    logic [2:0] credits;

    fifo_link_tx #(.DATA_SIZE(8), .CREDITS(CR), .CREDIT_W(3)) dut (
        .clk(clk), .rstN(rstN), .enable(enable), .drainReq(drainReq),
        .fifoData(fifoData), .fifoEmpty(fifoEmpty), .fifoRead(fifoRead),
        .linkValid(linkValid), .linkData(linkData), .creditReturn(creditReturn),
        .credits(credits), .busy(busy), .drained(drained), .creditErr(creditErr)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: local FIFO contents, tokens in flight to the remote side, mode
    logic [7:0] q[$];
    int         m_out, m_mode, dcount;
    logic       m_lv, m_err, m_drained;
    logic [7:0] m_ld;

    task automatic do_reset();
        @(negedge clk);
        rstN = 1'b0;
        enable = 1'b0; drainReq = 1'b0; creditReturn = 1'b0; fifoEmpty = 1'b1; fifoData = '0;
        @(posedge clk);
        #1 rstN = 1'b1;
        q.delete();
        m_out = 0; m_mode = 0; m_lv = 1'b0; m_ld = '0; m_err = 1'b0; m_drained = 1'b0; dcount = 0;
    endtask

    task automatic tick(input logic en, input logic dr, input logic ret);
        logic s, done;
        @(negedge clk);
        enable = en; drainReq = dr; creditReturn = ret;
        fifoEmpty = q.size() == 0;
        fifoData = fifoEmpty ? 8'h00 : q[0];
        #1;
        s = m_mode != 0 && q.size() > 0 && m_out < CR;
        chk("fifoRead", fifoRead, s);
        chk("linkValid", linkValid, m_lv);
        chk("linkData", linkData, m_ld);
        chk("credits", credits, CR - m_out);
        chk("busy", busy, m_mode != 0);
        chk("drained", drained, m_drained);
        chk("creditErr", creditErr, m_err);
        if (fifoRead && fifoEmpty) chk("read_when_empty", 1, 0);
        if (drained) dcount++;
        done = m_mode == 2 && q.size() == 0 && m_out == 0;
        m_lv = s;
        if (s) m_ld = q.pop_front();
        if (ret && !s && m_out == 0) m_err = 1'b1;
        else m_out = m_out + int'(s) - int'(ret);
        m_drained = done;
        m_mode = m_mode == 0 ? (en ? 1 : 0) :
                 m_mode == 1 ? (dr ? 2 : (en ? 1 : 0)) :
                 (done ? 0 : 2);
    endtask

    typedef struct {
        bit rst, en, dr, emp; logic [7:0] d; bit ret;
        bit rd, lv; logic [7:0] ld; logic [2:0] cr; bit bsy;
    } vec_t;
    vec_t vecs[22];

    initial begin
        vecs[0]  = '{1,1,0,0,8'h11,0, 0,0,8'h00,3'd4,0};
        vecs[1]  = '{0,1,0,0,8'h11,0, 1,0,8'h00,3'd4,1};
        vecs[2]  = '{0,1,0,0,8'h22,0, 1,1,8'h11,3'd3,1};
        vecs[3]  = '{0,1,0,0,8'h33,0, 1,1,8'h22,3'd2,1};
        vecs[4]  = '{0,1,0,1,8'h00,0, 0,1,8'h33,3'd1,1};
        vecs[5]  = '{0,1,0,1,8'h00,0, 0,0,8'h33,3'd1,1};
        vecs[6]  = '{1,1,0,0,8'hA1,0, 0,0,8'h00,3'd4,0};
        vecs[7]  = '{0,1,0,0,8'hA1,0, 1,0,8'h00,3'd4,1};
        vecs[8]  = '{0,1,0,0,8'hA2,0, 1,1,8'hA1,3'd3,1};
        vecs[9]  = '{0,1,0,0,8'hA3,0, 1,1,8'hA2,3'd2,1};
        vecs[10] = '{0,1,0,0,8'hA4,0, 1,1,8'hA3,3'd1,1};
        vecs[11] = '{0,1,0,0,8'hA5,0, 0,1,8'hA4,3'd0,1};
        vecs[12] = '{0,1,0,0,8'hA5,0, 0,0,8'hA4,3'd0,1};
        vecs[13] = '{0,1,0,0,8'hA5,1, 0,0,8'hA4,3'd0,1};
        vecs[14] = '{0,1,0,0,8'hA5,0, 1,0,8'hA4,3'd1,1};
        vecs[15] = '{0,1,0,0,8'hA6,0, 0,1,8'hA5,3'd0,1};
        vecs[16] = '{0,1,0,0,8'hA6,1, 0,0,8'hA5,3'd0,1};
        vecs[17] = '{0,1,0,0,8'hA6,1, 1,0,8'hA5,3'd1,1};
        vecs[18] = '{0,1,0,0,8'hA7,1, 1,1,8'hA6,3'd1,1};
        vecs[19] = '{0,1,0,0,8'hA8,1, 1,1,8'hA7,3'd1,1};
        vecs[20] = '{0,0,0,0,8'hA9,0, 1,1,8'hA8,3'd1,1};
        vecs[21] = '{0,0,0,0,8'hAA,0, 0,1,8'hA9,3'd0,0};

        #12;
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            @(negedge clk);
            enable = vecs[i].en; drainReq = vecs[i].dr; fifoEmpty = vecs[i].emp;
            fifoData = vecs[i].d; creditReturn = vecs[i].ret;
            #1;
            chk($sformatf("v%0d_fifoRead", i), fifoRead, vecs[i].rd);
            chk($sformatf("v%0d_linkValid", i), linkValid, vecs[i].lv);
            chk($sformatf("v%0d_linkData", i), linkData, vecs[i].ld);
            chk($sformatf("v%0d_credits", i), credits, vecs[i].cr);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].bsy);
        end

        // orderly drain: 2 queued, 2 in flight when drainReq arrives
        do_reset();
        for (int i = 0; i < 4; i++) q.push_back(8'hC0 + 8'(i));
        tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
        tick(1, 1, 0); tick(0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 1);
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        chk("drain_pulses", dcount, 1);
        chk("drain_busy", busy, 0);
        chk("drain_credits", credits, CR);

        // illegal credit return while idle at full credit
        do_reset();
        tick(0, 0, 1);
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        tick(1, 0, 1);
        chk("err_sticky", creditErr, 1);
        do_reset();
        tick(0, 0, 0);

        // asynchronous reset between edges with a token on the link
        do_reset();
        for (int i = 0; i < 3; i++) q.push_back(8'h50 + 8'(i));
        tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
        @(negedge clk);
        #1;
        chk("pre_rst_linkValid", linkValid, 1);
        chk("pre_rst_credits", credits, 1);
        #1 rstN = 1'b0;
        #1;
        chk("async_linkValid", linkValid, 0);
        chk("async_credits", credits, CR);
        chk("async_busy", busy, 0);
        chk("async_fifoRead", fifoRead, 0);
        do_reset();

        // randomized traffic with a legal remote consumer
        for (int c = 0; c < 3000; c++) begin
            if (q.size() < 8 && $urandom_range(2) != 0) q.push_back(8'($urandom));
            tick($urandom_range(7) != 0, $urandom_range(39) == 0,
                 m_out > 0 && $urandom_range(2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
